// File: rtl/wd_pkg.sv
// Shared types for the multi-channel watchdog: channel state encoding and
// the first-fault index width helper.
package wd_pkg;

    typedef enum logic [1:0] {
        DISABLED = 2'd0,
        ARMED    = 2'd1,
        WARN     = 2'd2,
        TRIPPED  = 2'd3
    } wd_state_t;

    // A single channel still gets a 1-bit index port.
    function automatic int first_ch_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/wd_channel.sv
// One watchdog channel: DISABLED/ARMED/WARN/TRIPPED FSM plus its idle counter.
// WD_WINDOW_EN adds the early-kick window and the early_kick flag.
module wd_channel
    import wd_pkg::*;
#(
    parameter int CNT_W           = 32,
    parameter int TIMEOUT_CYCLES  = 1000000,
    parameter int WARN_CYCLES     = 750000,
    parameter int MIN_KICK_CYCLES = 1000
) (
    input  logic clk,
    input  logic rstn,
    input  logic enable,
    input  logic heartbeat,
    input  logic force_trip,
    input  logic clear,
    output logic warning,
    output logic triggered,
`ifdef WD_WINDOW_EN
    output logic early_kick,
`endif
    output logic tripped_nxt
);

    localparam logic [CNT_W-1:0] WARN_M1 = CNT_W'(WARN_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_M1  = CNT_W'(TIMEOUT_CYCLES - 1);

    wd_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef WD_WINDOW_EN
    localparam logic [CNT_W-1:0] MIN_KICK = CNT_W'(MIN_KICK_CYCLES);
    logic early_q, early_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
`ifdef WD_WINDOW_EN
        early_d = early_q;
`endif
        // A forced trip freezes the counter wherever it stood.
        if (force_trip && state_q != DISABLED) begin
            state_d = TRIPPED;
        end else begin
            case (state_q)
                DISABLED: begin
                    cnt_d = '0;
                    if (enable) state_d = ARMED;
                end
                TRIPPED: begin
                    if (clear) begin
                        state_d = DISABLED;
                        cnt_d   = '0;
`ifdef WD_WINDOW_EN
                        early_d = 1'b0;
`endif
                    end
                end
                default: begin
                    if (!enable) begin
                        state_d = DISABLED;
                        cnt_d   = '0;
                    end else if (heartbeat) begin
`ifdef WD_WINDOW_EN
                        if (state_q == ARMED && cnt_q < MIN_KICK) begin
                            state_d = TRIPPED;
                            early_d = 1'b1;
                        end else begin
                            state_d = ARMED;
                            cnt_d   = '0;
                        end
`else
                        state_d = ARMED;
                        cnt_d   = '0;
`endif
                    end else if (cnt_q == TMO_M1) begin
                        state_d = TRIPPED;
                        cnt_d   = cnt_q + 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == WARN_M1) state_d = WARN;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= DISABLED;
            cnt_q   <= '0;
`ifdef WD_WINDOW_EN
            early_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
`ifdef WD_WINDOW_EN
            early_q <= early_d;
`endif
        end
    end

    assign warning     = (state_q == WARN);
    assign triggered   = (state_q == TRIPPED);
    assign tripped_nxt = (state_d == TRIPPED);
`ifdef WD_WINDOW_EN
    assign early_kick  = early_q;
`endif

endmodule

// File: rtl/multi_channel_watchdog.sv
// NUM_CH independent heartbeat watchdogs with aggregated safe_shutdown and a
// first-fault channel latch. Define WD_WINDOW_EN for the windowed variant.
module multi_channel_watchdog
    import wd_pkg::*;
#(
    parameter int NUM_CH          = 4,
    parameter int CNT_W           = 32,
    parameter int TIMEOUT_CYCLES  = 1000000,
    parameter int WARN_CYCLES     = 750000,
    parameter int MIN_KICK_CYCLES = 1000
) (
    input  logic                                clk,
    input  logic                                rstn,
    input  logic [NUM_CH-1:0]                   enable,
    input  logic [NUM_CH-1:0]                   heartbeat,
    input  logic                                force_reset,
    input  logic                                clear,
    output logic [NUM_CH-1:0]                   warning,
    output logic [NUM_CH-1:0]                   triggered,
`ifdef WD_WINDOW_EN
    output logic [NUM_CH-1:0]                   early_kick,
`endif
    output logic                                safe_shutdown,
    output logic [first_ch_width(NUM_CH)-1:0]   first_ch,
    output logic                                first_valid
);

    localparam int FC_W = first_ch_width(NUM_CH);

    if (WARN_CYCLES < 1 || WARN_CYCLES >= TIMEOUT_CYCLES) begin : g_bad_warn
        $error("WARN_CYCLES must satisfy 1 <= WARN_CYCLES < TIMEOUT_CYCLES");
    end
    if (CNT_W < 63 && longint'(TIMEOUT_CYCLES) >= (longint'(1) << CNT_W)) begin : g_bad_tmo
        $error("TIMEOUT_CYCLES does not fit in CNT_W bits");
    end
`ifdef WD_WINDOW_EN
    if (MIN_KICK_CYCLES >= WARN_CYCLES) begin : g_bad_min
        $error("MIN_KICK_CYCLES must be below WARN_CYCLES");
    end
`else
    if (MIN_KICK_CYCLES < 0) begin : g_bad_min
        $error("MIN_KICK_CYCLES must be non-negative");
    end
`endif

    logic [NUM_CH-1:0] tripped_nxt;
    logic [FC_W-1:0]   first_idx;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        wd_channel #(
            .CNT_W          (CNT_W),
            .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
            .WARN_CYCLES    (WARN_CYCLES),
            .MIN_KICK_CYCLES(MIN_KICK_CYCLES)
        ) u_ch (
            .clk        (clk),
            .rstn       (rstn),
            .enable     (enable[i]),
            .heartbeat  (heartbeat[i]),
            .force_trip (force_reset),
            .clear      (clear),
            .warning    (warning[i]),
            .triggered  (triggered[i]),
`ifdef WD_WINDOW_EN
            .early_kick (early_kick[i]),
`endif
            .tripped_nxt(tripped_nxt[i])
        );
    end

    // Lowest channel that will be TRIPPED after this edge.
    always_comb begin
        first_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (tripped_nxt[i]) first_idx = FC_W'(i);
        end
    end

    // Re-latch only when no currently tripped channel survives the edge, so a
    // simultaneous clear-and-new-trip reports the new fault, not a stale one.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            safe_shutdown <= 1'b0;
            first_valid   <= 1'b0;
            first_ch      <= '0;
        end else begin
            safe_shutdown <= |triggered;
            if (!(|tripped_nxt)) begin
                first_valid <= 1'b0;
                first_ch    <= '0;
            end else if (!first_valid || !(|(tripped_nxt & triggered))) begin
                first_valid <= 1'b1;
                first_ch    <= first_idx;
            end
        end
    end

endmodule

// File: tb/tb_multi_channel_watchdog.sv
// Directed bench for multi_channel_watchdog (NUM_CH=2, TIMEOUT=8, WARN=6,
// MIN_KICK=2). Covers WD_WINDOW_EN when that macro is defined.
module tb_multi_channel_watchdog;
    import wd_pkg::*;

    logic       clk = 1'b0;
    logic       rstn;
    logic [1:0] enable;
    logic [1:0] heartbeat;
    logic       force_reset;
    logic       clear;
    logic [1:0] warning;
    logic [1:0] triggered;
    logic       safe_shutdown;
    logic [0:0] first_ch;
    logic       first_valid;
`ifdef WD_WINDOW_EN
    logic [1:0] early_kick;
`endif

    int n_run  = 0;
    int n_fail = 0;
    logic seen_bad;

    multi_channel_watchdog #(
        .NUM_CH         (2),
        .CNT_W          (8),
        .TIMEOUT_CYCLES (8),
        .WARN_CYCLES    (6),
        .MIN_KICK_CYCLES(2)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .enable       (enable),
        .heartbeat    (heartbeat),
        .force_reset  (force_reset),
        .clear        (clear),
        .warning      (warning),
        .triggered    (triggered),
`ifdef WD_WINDOW_EN
        .early_kick   (early_kick),
`endif
        .safe_shutdown(safe_shutdown),
        .first_ch     (first_ch),
        .first_valid  (first_valid)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        rstn = 1'b0; enable = 2'b00; heartbeat = 2'b00;
        force_reset = 1'b0; clear = 1'b0;
        tick(2);
        chk("rst_warn", 32'(warning), 0);
        chk("rst_trig", 32'(triggered), 0);
        chk("rst_ss",   32'(safe_shutdown), 0);
        chk("rst_fv",   32'(first_valid), 0);
        chk("rst_fc",   32'(first_ch), 0);

        // Starve ch0: ARMED entry at first edge, WARN +6, TRIPPED +8.
        rstn = 1'b1; enable = 2'b01;
        tick(1);
        tick(5);
        chk("starve_warn5", 32'(warning), 0);
        tick(1);
        chk("starve_warn6", 32'(warning), 32'b01);
        chk("starve_trig6", 32'(triggered), 0);
        tick(1);
        chk("starve_trig7", 32'(triggered), 0);
        tick(1);
        chk("starve_trig8", 32'(triggered), 32'b01);
        chk("starve_ss8",   32'(safe_shutdown), 0);
        chk("starve_fv",    32'(first_valid), 1);
        chk("starve_fc",    32'(first_ch), 0);
        tick(1);
        chk("starve_ss9",   32'(safe_shutdown), 1);
        heartbeat = 2'b01;
        tick(1);
        chk("trip_sticky",  32'(triggered), 32'b01);
        heartbeat = 2'b00;

        // Clear, then re-arm on the following edge (enable still high).
        clear = 1'b1;
        tick(1);
        chk("clr_trig", 32'(triggered), 0);
        chk("clr_fv",   32'(first_valid), 0);
        chk("clr_ss",   32'(safe_shutdown), 1);
        clear = 1'b0;
        tick(1);
        chk("clr_ss2",  32'(safe_shutdown), 0);

        // Kick every 5 cycles for 100 cycles: counter peaks at 4.
        seen_bad = 1'b0;
        for (int k = 0; k < 20; k++) begin
            heartbeat = 2'b00;
            for (int j = 0; j < 4; j++) begin
                tick(1);
                seen_bad |= warning[0] | triggered[0];
            end
            heartbeat = 2'b01;
            tick(1);
            seen_bad |= warning[0] | triggered[0];
        end
        heartbeat = 2'b00;
        chk("kick_ok", 32'(seen_bad), 0);

        // Kick at counter 7 while in WARN rescues the channel.
        tick(6);
        chk("late_warn", 32'(warning), 32'b01);
        tick(1);
        heartbeat = 2'b01;
        tick(1);
        heartbeat = 2'b00;
        chk("late_warn_drop", 32'(warning), 0);
        chk("late_no_trip",   32'(triggered), 0);
        tick(5);
        chk("late_restart5",  32'(warning), 0);
        tick(1);
        chk("late_restart6",  32'(warning), 32'b01);

        // Both channels: ch1 starved first, ch0 kicked at counter 3.
        enable = 2'b00;
        tick(1);
        enable = 2'b11;
        tick(1);
        for (int k = 1; k <= 8; k++) begin
            heartbeat = (k % 4 == 0) ? 2'b01 : 2'b00;
            tick(1);
        end
        heartbeat = 2'b00;
        chk("ch1_trig", 32'(triggered), 32'b10);
        chk("ch1_fv",   32'(first_valid), 1);
        chk("ch1_fc",   32'(first_ch), 1);
        tick(8);
        chk("both_trig", 32'(triggered), 32'b11);
        chk("both_fc",   32'(first_ch), 1);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        chk("both_clr_trig", 32'(triggered), 0);
        chk("both_clr_fv",   32'(first_valid), 0);
        chk("both_clr_fc",   32'(first_ch), 0);
        tick(7);
        chk("both_rearm", 32'(warning), 32'b11);

        // Forced trip, then force wins over a simultaneous clear.
        force_reset = 1'b1;
        tick(1);
        force_reset = 1'b0;
        chk("force_trig", 32'(triggered), 32'b11);
        chk("force_warn", 32'(warning), 0);
        chk("force_fc",   32'(first_ch), 0);
        chk("force_fv",   32'(first_valid), 1);
        tick(1);
        chk("force_ss",   32'(safe_shutdown), 1);
        force_reset = 1'b1; clear = 1'b1;
        tick(1);
        force_reset = 1'b0;
        chk("force_clr_trig", 32'(triggered), 32'b11);
        tick(1);
        clear = 1'b0;
        chk("clr_after_force", 32'(triggered), 0);

        // Force leaves a DISABLED channel alone.
        enable = 2'b01;
        tick(1);
        force_reset = 1'b1;
        tick(1);
        force_reset = 1'b0;
        chk("force_dis", 32'(triggered), 32'b01);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;

        // Reset while ch0 is in WARN.
        tick(7);
        chk("pre_rst_warn", 32'(warning), 32'b01);
        rstn = 1'b0;
        tick(1);
        chk("mid_rst_warn", 32'(warning), 0);
        chk("mid_rst_trig", 32'(triggered), 0);
        chk("mid_rst_ss",   32'(safe_shutdown), 0);
        chk("mid_rst_fv",   32'(first_valid), 0);
        rstn = 1'b1;

`ifdef WD_WINDOW_EN
        // Kick at counter 1 is too early.
        tick(2);
        heartbeat = 2'b01;
        tick(1);
        heartbeat = 2'b00;
        chk("early_trig", 32'(triggered), 32'b01);
        chk("early_flag", 32'(early_kick), 32'b01);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        chk("early_clr", 32'(early_kick), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
